// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared N-bit ripple-carry adder
// steps through WORDS words, least-significant word first, with a registered carry chain.

module n_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] c;

    // NOTE: every variable in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[N];
    end
endmodule

module mp_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   result,
    output logic                 c_out,
    output logic                 overflow,
    output logic                 busy
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [WORDS-1:0][N-1:0]  a_q;
    logic [WORDS-1:0][N-1:0]  b_q;
    logic [WORDS-1:0][N-1:0]  res_q;
    logic [IW-1:0]            idx;
    logic                     carry;
    logic [N-1:0]             sum_word;
    logic                     add_co;
    logic                     accept;

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;

    n_adder #(.N(N)) u_adder (
        .a     (a_q[idx]),
        .b     (b_q[idx]),
        .c_in  (carry),
        .sum   (sum_word),
        .c_out (add_co)
    );

    // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a_in;
            b_q <= sub ? ~b_in : b_in;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            res_q    <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        idx   <= '0;
                        carry <= sub;
                    end
                end
                RUN: begin
                    res_q[idx] <= sum_word;
                    carry      <= add_co;
                    if (idx == LAST) begin
                        // Signed overflow: equal operand signs but a different result sign.
                        c_out    <= add_co;
                        overflow <= (a_q[WORDS-1][N-1] == b_q[WORDS-1][N-1]) &&
                                    (sum_word[N-1] != a_q[WORDS-1][N-1]);
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: three parameterisations, scoreboard queues
// filled on accept and drained on each output handshake.

module tb_mp_add_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        ov;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // u0: N=8 WORDS=4; u1: N=8 WORDS=1; u2: N=1 WORDS=8
    logic        rst0, iv0, ir0, s0, vld0, or0, co0, ovf0, busy0;
    logic [31:0] a0, b0, r0;
    logic        rst1, iv1, ir1, s1, vld1, or1, co1, ovf1, busy1;
    logic [7:0]  a1, b1, r1;
    logic        rst2, iv2, ir2, s2, vld2, or2, co2, ovf2, busy2;
    logic [7:0]  a2, b2, r2;

    mp_add_seq #(.N(8), .WORDS(4)) u0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a_in(a0), .b_in(b0),
        .sub(s0), .out_valid(vld0), .out_ready(or0), .result(r0), .c_out(co0),
        .overflow(ovf0), .busy(busy0));

    mp_add_seq #(.N(8), .WORDS(1)) u1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a_in(a1), .b_in(b1),
        .sub(s1), .out_valid(vld1), .out_ready(or1), .result(r1), .c_out(co1),
        .overflow(ovf1), .busy(busy1));

    mp_add_seq #(.N(1), .WORDS(8)) u2 (
        .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .a_in(a2), .b_in(b2),
        .sub(s2), .out_valid(vld2), .out_ready(or2), .result(r2), .c_out(co2),
        .overflow(ovf2), .busy(busy2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input int w);
        logic [63:0] m, be, full;
        exp_t e;
        m    = (64'd1 << w) - 64'd1;
        be   = (s ? ~b : b) & m;
        full = (a & m) + be + 64'(s);
        e.r  = full & m;
        e.c  = full[w];
        e.ov = (a[w-1] == be[w-1]) && (e.r[w-1] != a[w-1]);
        return e;
    endfunction

    function automatic logic rdy(input int u);
        case (u)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic vld(input int u);
        case (u)
            0:       return vld0;
            1:       return vld1;
            default: return vld2;
        endcase
    endfunction

    function automatic logic bsy(input int u);
        case (u)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic drive(input int u, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic s);
        case (u)
            0: begin iv0 = v; a0 = a[31:0]; b0 = b[31:0]; s0 = s; end
            1: begin iv1 = v; a1 = a[7:0];  b1 = b[7:0];  s1 = s; end
            default: begin iv2 = v; a2 = a[7:0]; b2 = b[7:0]; s2 = s; end
        endcase
    endtask

    // Called and returns at posedge+#1; returns just after the accept edge.
    task automatic send(input int u, input logic [63:0] a, input logic [63:0] b, input logic s);
        int n = 0;
        int w;
        w = (u == 0) ? 32 : 8;
        while (!rdy(u) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("ready_u%0d", u), rdy(u), 1'b1);
        drive(u, 1'b1, a, b, s);
        case (u)
            0:       q0.push_back(model(a, b, s, w));
            1:       q1.push_back(model(a, b, s, w));
            default: q2.push_back(model(a, b, s, w));
        endcase
        @(posedge clk); #1;
        drive(u, 1'b0, a, b, s);
    endtask

    // Counts edges from the accept edge until out_valid; busy must hold meanwhile.
    task automatic wait_valid(input int u, output int edges);
        edges = 0;
        while (!vld(u) && edges < 50) begin
            check($sformatf("busy_u%0d", u), bsy(u), 1'b1);
            @(posedge clk); #1;
            edges++;
        end
        check($sformatf("valid_u%0d", u), vld(u), 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst0 && vld0 && or0) begin
            if (q0.size() == 0) check("sb0_empty", 1, 0);
            else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_result", r0, e.r);
                check("u0_c_out", co0, e.c);
                check("u0_overflow", ovf0, e.ov);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && vld1 && or1) begin
            if (q1.size() == 0) check("sb1_empty", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                check("u1_result", r1, e.r);
                check("u1_c_out", co1, e.c);
                check("u1_overflow", ovf1, e.ov);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && vld2 && or2) begin
            if (q2.size() == 0) check("sb2_empty", 1, 0);
            else begin
                exp_t e;
                e = q2.pop_front();
                check("u2_result", r2, e.r);
                check("u2_c_out", co2, e.c);
                check("u2_overflow", ovf2, e.ov);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int n;
        rst0 = 1; rst1 = 1; rst2 = 1;
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0);
        or0 = 1; or1 = 1; or2 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", ir0, 1);
        check("rst_out_valid", vld0, 0);
        check("rst_busy", busy0, 0);
        check("rst_result", r0, 0);
        check("rst_c_out", co0, 0);
        check("rst_overflow", ovf0, 0);
        rst0 = 0; rst1 = 0; rst2 = 0;

        // Basic add with carry into word 1, latency in edges equals WORDS.
        send(0, 32'h0000_00FF, 32'h0000_0001, 0);
        wait_valid(0, e);
        check("lat_u0", e, 4);
        send(0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        send(0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        send(0, 32'h0000_0005, 32'h0000_0007, 1);
        send(0, 32'h8000_0000, 32'h0000_0001, 1);
        wait_valid(0, e);

        // Backpressure: hold DONE, ignore in_valid pulses during RUN and DONE.
        @(posedge clk); #1;
        or0 = 0;
        send(0, 32'h0A0B_0C0D, 32'h0101_0101, 0);
        drive(0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        check("bp_run_in_ready", ir0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        wait_valid(0, e);
        for (int i = 0; i < 3; i++) begin
            drive(0, (i == 1), 32'h5555_5555, 32'h3333_3333, 0);
            check("bp_valid", vld0, 1);
            check("bp_in_ready", ir0, 0);
            check("bp_result", r0, q0[0].r);
            check("bp_c_out", co0, q0[0].c);
            check("bp_overflow", ovf0, q0[0].ov);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0);
        check("bp_hold_result", r0, 32'h0B0C_0D0E);
        or0 = 1;
        @(posedge clk); #1;
        check("bp_release_in_ready", ir0, 1);
        check("bp_release_valid", vld0, 0);
        send(0, 32'h0000_0001, 32'h0000_0002, 0);
        wait_valid(0, e);

        // Reset two RUN cycles into an operation; it must be discarded.
        @(posedge clk); #1;
        n = 0;
        while (!ir0 && n < 50) begin @(posedge clk); #1; n++; end
        drive(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst0 = 1;
        @(posedge clk); #1;
        check("mid_rst_valid", vld0, 0);
        check("mid_rst_in_ready", ir0, 1);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_result", r0, 0);
        check("mid_rst_c_out", co0, 0);
        check("mid_rst_overflow", ovf0, 0);
        rst0 = 0;
        send(0, 32'h1234_5678, 32'h1111_1111, 0);
        wait_valid(0, e);
        check("post_rst_result", r0, 32'h2345_6789);

        for (int i = 0; i < 8; i++) send(0, 64'($urandom), 64'($urandom), 1'($urandom));

        // WORDS=1: single RUN cycle.
        send(1, 8'hFF, 8'h01, 0);
        wait_valid(1, e);
        check("lat_u1", e, 1);
        send(1, 8'h7F, 8'h01, 0);
        send(1, 8'h80, 8'h01, 1);
        send(1, 8'h03, 8'h09, 1);

        // N=1, WORDS=8: bit-serial against the full-width model.
        send(2, 8'hA5, 8'h5B, 0);
        wait_valid(2, e);
        check("lat_u2", e, 8);
        for (int i = 0; i < 20; i++) send(2, 64'($urandom_range(255)), 64'($urandom_range(255)), 1'($urandom));

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        check("drain_q2", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add/subtract sequencer. It accepts WORDS*N-bit operands through a valid/ready handshake and drives one internal N-bit ripple-carry adder (n_adder, parameter N) once per cycle, least-significant word first. The carry is chained through a register between words. The block is the reusable wide-arithmetic engine for datapaths that cannot afford a full-width combinational adder.

Parameters:
N, 8, width of the shared n_adder word (bits); must be >= 1
WORDS, 4, number of N-bit words per operand; must be >= 1; total width W = N*WORDS

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands
a_in  input  W  operand A (unsigned or two's complement)
b_in  input  W  operand B
sub  input  1  0: A+B; 1: A-B; sampled with operands
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  W  sum/difference
c_out  output  1  final carry out of MSB word (sub: 1 = no borrow)
overflow  output  1  signed overflow of the full W-bit operation
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Reset and power-up state is IDLE.
- Reset (any state, including mid-RUN): state=IDLE; result, c_out, overflow, out_valid, word index, carry register all 0; in_ready=1 in the first cycle after reset; any in-flight operation is discarded.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: on in_valid&&in_ready, latch A, B_eff = sub ? ~b_in : b_in, carry = sub, idx = 0, and record sign bits A[W-1] and B_eff[W-1]. Go to RUN. in_valid with in_ready low is ignored and has no effect.
- RUN, each cycle: drive adder with A[idx*N +: N], B_eff[idx*N +: N], c_in = carry. Write the sum into result[idx*N +: N], set carry <= adder c_out, increment idx.
- RUN exit: on the cycle idx==WORDS-1, also latch c_out <= adder c_out and overflow <= (signA==signB_eff) && (sum MSB != signA), then go to DONE.
- DONE: result, c_out and overflow are held stable. On out_ready, go to IDLE. out_ready in any other state is ignored.
- Latency: operands accepted at edge T; RUN occupies edges T+1..T+WORDS; out_valid is high starting the cycle after edge T+WORDS.
- Throughput: minimum initiation interval is WORDS+2 cycles (no overlap of accept and deliver).
- result/c_out/overflow keep their last values after the DONE->IDLE transition and change only during the next RUN.
- WORDS==1: RUN lasts exactly one cycle.
- Arithmetic is modulo 2^W. The idx counter is sized clog2(WORDS) bits, with a minimum of 1 bit, and never wraps past WORDS-1.
- Exactly one n_adder instance. No combinational path from inputs to outputs except in_ready/out_valid, which are decoded from state only.

Test Plan:
- (N=8, WORDS=4) a=0x000000FF, b=0x00000001, sub=0 -> result=0x00000100, c_out=0, overflow=0; out_valid first high 5 cycles after the accept edge; busy high throughout.
- a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, c_out=1, overflow=0 (carry ripples through all 4 words); a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, c_out=0.
- sub=1, a=0x00000005, b=0x00000007 -> result=0xFFFFFFFE, c_out=0, overflow=0; a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1, c_out=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, result, c_out and overflow stay stable; pulse in_valid with new operands during RUN/DONE -> ignored, in_ready=0; assert out_ready -> in_ready=1 the next cycle, and a new accept produces the new result.
- Reset mid-op: assert rst after 2 RUN cycles -> next cycle state=IDLE, out_valid=0, result=0, c_out=0, overflow=0, in_ready=1; the following transaction 0x12345678+0x11111111 -> 0x23456789.
- Parameter sweep: WORDS=1,N=8 (0xFF+0x01 -> 0x00, c_out=1, latency 2); N=1,WORDS=8, random operands checked against a W-bit reference model.
